// File: rtl/dot_matrix_pkg.sv
// Shared constants, FSM state type and row-strobe decoder for the dot-matrix capture block.
package dot_matrix_pkg;

  localparam int unsigned DM_ROWS = 8;
  localparam int unsigned DM_COLS = 16;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] idx;
  } row_dec_t;

  // legal is set only when exactly one bit of the active-low strobe is low
  function automatic row_dec_t row_decode(input logic [DM_ROWS-1:0] row_n);
    row_dec_t    d;
    int unsigned zeros;
    d     = '0;
    zeros = 0;
    for (int unsigned i = 0; i < DM_ROWS; i++) begin
      if (!row_n[i]) begin
        zeros++;
        d.idx = 3'(i);
      end
    end
    d.legal = (zeros == 1);
    return d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a configurable reset value; clock clk, reset rst (sync, active-low).
module sync_2ff
  import dot_matrix_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dot_matrix_capture.sv
// Passive 8x16 dot-matrix scan receiver: rebuilds frames into a readable buffer and flags bad strobes.
// Optional frame_valid timeout is enabled by defining CAPTURE_TIMEOUT_EN.
module dot_matrix_capture
  import dot_matrix_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DM_ROWS-1:0] row_n,
  input  logic [DM_COLS-1:0] col,
  input  logic [2:0]         rd_addr,
  output logic [DM_COLS-1:0] rd_data,
  output logic               frame_valid,
  output logic               frame_pulse,
  output logic               scan_err,
  output logic [7:0]         err_count
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 15 || TIMEOUT == '0) begin : g_bad_param
    $error("dot_matrix_capture: SETTLE must be 1..15 and TIMEOUT nonzero");
  end

  logic [DM_ROWS-1:0] row_s, row_prev;
  logic [DM_COLS-1:0] col_s;

  // Row history resets to blank so a reset-time blank strobe is not seen as a change
  sync_2ff #(.WIDTH(DM_ROWS), .RST_VAL('1)) u_sync_row (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (row_s)
  );

  sync_2ff #(.WIDTH(DM_COLS), .RST_VAL('0)) u_sync_col (
    .clk (clk),
    .rst (rst),
    .d   (col),
    .q   (col_s)
  );

  cap_state_t                       state;
  logic [3:0]                       cnt;
  logic [DM_ROWS-1:0][DM_COLS-1:0]  shadow, shadow_nxt, front;
  logic [DM_ROWS-1:0]               seen, seen_nxt, one_hot;
  row_dec_t                         dec;
  logic                             row_chg, eval, wr, bad, complete;

  always_comb begin
    row_chg    = (row_s != row_prev);
    dec        = row_decode(row_s);
    eval       = (state == ST_SETTLE) && !row_chg && (cnt == SETTLE_M1);
    wr         = eval && dec.legal;
    bad        = eval && !dec.legal && !(&row_s);
    one_hot    = '0;
    shadow_nxt = shadow;
    if (wr) begin
      one_hot[dec.idx]    = 1'b1;
      shadow_nxt[dec.idx] = col_s;
    end
    seen_nxt = seen | one_hot;
    complete = wr && (seen_nxt == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_prev <= '1;
      state    <= ST_WAIT;
      cnt      <= '0;
    end else begin
      row_prev <= row_s;
      case (state)
        ST_WAIT: begin
          if (row_chg) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (row_chg)                cnt   <= '0;
          else if (cnt == SETTLE_M1)  state <= ST_HELD;
          else                        cnt   <= cnt + 4'd1;
        end
        ST_HELD: begin
          if (row_chg) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // Front takes shadow_nxt so the row completing the frame lands in the same edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow      <= '0;
      front       <= '0;
      seen        <= '0;
      frame_pulse <= 1'b0;
      scan_err    <= 1'b0;
      err_count   <= '0;
      rd_data     <= '0;
    end else begin
      shadow      <= shadow_nxt;
      seen        <= complete ? '0 : seen_nxt;
      frame_pulse <= complete;
      scan_err    <= bad;
      if (complete) front <= shadow_nxt;
      if (bad && (err_count != '1)) err_count <= err_count + 8'd1;
      rd_data     <= front[rd_addr];
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt      <= '0;
      frame_valid <= 1'b0;
    end else if (complete) begin
      to_cnt      <= '0;
      frame_valid <= 1'b1;
    end else if (to_cnt == TIMEOUT) begin
      frame_valid <= 1'b0;
    end else begin
      to_cnt      <= to_cnt + 32'd1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst)          frame_valid <= 1'b0;
    else if (complete) frame_valid <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dot_matrix_capture.sv
// Scoreboard bench for dot_matrix_capture; covers the CAPTURE_TIMEOUT_EN build when that macro is defined.
module tb_dot_matrix_capture;

  localparam int unsigned SETTLE_C  = 4;
  localparam logic [31:0] TIMEOUT_C = 32'd100;

  typedef logic [7:0][15:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  row_n = 8'hFF;
  logic [15:0] col = '0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        frame_valid, frame_pulse, scan_err;
  logic [7:0]  err_count;

  dot_matrix_capture #(.SETTLE(SETTLE_C), .TIMEOUT(TIMEOUT_C)) dut (
    .clk         (clk),
    .rst         (rst),
    .row_n       (row_n),
    .col         (col),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_pulse (frame_pulse),
    .scan_err    (scan_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model state
  frame_t      m_shadow = '0;
  logic [7:0]  m_seen   = '0;
  logic [7:0]  m_last   = 8'hFF;
  int unsigned m_err    = 0;
  frame_t      cur_front = '0;
  frame_t      frame_q[$];
  int unsigned err_q[$];
  bit          chk_next = 0;

  task automatic model_eval(input logic [7:0] rn, input logic [15:0] c);
    int unsigned zeros = 0;
    int unsigned idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (rn[i] == 1'b0) begin
        zeros++;
        idx = i;
      end
    end
    if (zeros == 1) begin
      m_shadow[idx] = c;
      m_seen[idx]   = 1'b1;
      if (m_seen == 8'hFF) begin
        frame_q.push_back(m_shadow);
        m_seen = '0;
      end
    end else if (zeros != 0) begin
      if (m_err < 255) m_err++;
      err_q.push_back(m_err);
    end
  endtask

  task automatic model_reset();
    m_shadow  = '0;
    m_seen    = '0;
    m_last    = 8'hFF;
    m_err     = 0;
    cur_front = '0;
    frame_q.delete();
    err_q.delete();
  endtask

  // Pattern is present on the pins for exactly `hold` cycles
  task automatic drive(input logic [7:0] rn, input logic [15:0] c, input int unsigned hold);
    @(posedge clk);
    #1;
    row_n = rn;
    col   = c;
    if (rn != m_last && hold >= SETTLE_C + 1) model_eval(rn, c);
    m_last = rn;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic scan_row(input int unsigned r, input logic [15:0] c);
    logic [7:0] rn;
    rn = ~(8'h01 << r);
    drive(rn, c, 12);
    drive(8'hFF, 16'h0000, 6);
  endtask

  task automatic read_front(input string tag, input frame_t exp);
    for (int a = 0; a < 8; a++) begin
      @(posedge clk);
      #1 rd_addr = 3'(a);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, a), rd_data, exp[a]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_next) begin
      check("rd_after_copy", rd_data, cur_front[rd_addr]);
      chk_next = 0;
    end
    if (frame_pulse) begin
      check("frame_q_depth", frame_q.size(), 1);
      if (frame_q.size() > 0) begin
        check("rd_same_cycle", rd_data, cur_front[rd_addr]);
        cur_front = frame_q.pop_front();
        chk_next  = 1;
      end
    end
    if (scan_err) begin
      check("err_q_depth", err_q.size(), 1);
      if (err_q.size() > 0) check("err_count", err_count, err_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    frame_t exp;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_pulse", frame_pulse, 0);
    check("rst_scan_err", scan_err, 0);
    check("rst_err_count", err_count, 0);

    // Descending scan
    for (int r = 7; r >= 0; r--) scan_row(r, 16'h0001 << r);
    check("fv_after_frame1", frame_valid, 1);
    for (int r = 0; r < 8; r++) exp[r] = 16'h0001 << r;
    read_front("frame1", exp);
    check("err_after_frame1", err_count, 0);

`ifdef CAPTURE_TIMEOUT_EN
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("fv_before_timeout", frame_valid, 1);
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("fv_after_timeout", frame_valid, 0);
    read_front("frame1_retained", exp);
`else
    repeat (120) @(posedge clk);
    @(negedge clk);
    check("fv_sticky", frame_valid, 1);
`endif

    // Ascending scan, then duplicate row 3 overwritten before completion
    for (int r = 0; r < 8; r++) scan_row(r, 16'hA000 | 16'(r));
    read_front("ascend", cur_front);
    scan_row(3, 16'h1234);
    scan_row(3, 16'hBEEF);
    for (int r = 0; r < 8; r++) if (r != 3) scan_row(r, 16'hC000 | 16'(r));
    @(posedge clk);
    #1 rd_addr = 3'd3;
    @(posedge clk);
    @(negedge clk);
    check("dup_row3", rd_data, 16'hBEEF);

    // Illegal strobe mid-frame leaves the shadow untouched
    scan_row(0, 16'h1111);
    scan_row(1, 16'h2222);
    drive(8'b1111_0011, 16'hDEAD, 10);
    drive(8'hFF, 16'h0000, 6);
    check("err_count_1", err_count, 1);
    for (int r = 2; r < 8; r++) scan_row(r, 16'h3300 | 16'(r));
    exp = m_shadow;
    read_front("after_err", exp);

    for (int i = 0; i < 299; i++) begin
      drive(8'b1111_0011, 16'hDEAD, 10);
      drive(8'hFF, 16'h0000, 6);
    end
    check("err_count_sat", err_count, 255);

    // Short glitch to an already-seen row must not overwrite it; rd_addr 5 across the copy edge
    @(posedge clk);
    #1 rd_addr = 3'd5;
    scan_row(5, 16'h5A5A);
    scan_row(0, 16'h0F0F);
    scan_row(1, 16'hF0F0);
    drive(8'b1111_1011, 16'h2222, 12);
    drive(8'b1101_1111, 16'hFFFF, 2);
    drive(8'b1111_1011, 16'h2222, 12);
    drive(8'hFF, 16'h0000, 6);
    for (int r = 3; r < 8; r++) if (r != 5) scan_row(r, 16'h7700 | 16'(r));
    @(negedge clk);
    check("glitch_row5", rd_data, 16'h5A5A);
    check("glitch_no_err", err_count, 255);

    // Reset mid-frame discards the partial frame
    for (int r = 0; r < 4; r++) scan_row(r, 16'hEE00 | 16'(r));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst2_rd_data", rd_data, 0);
    check("rst2_frame_valid", frame_valid, 0);
    check("rst2_err_count", err_count, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int r = 4; r < 8; r++) scan_row(r, 16'h4400 | 16'(r));
    check("partial_no_frame", frame_valid, 0);
    for (int r = 0; r < 4; r++) scan_row(r, 16'h0400 | 16'(r));
    check("fv_after_rst_frame", frame_valid, 1);
    for (int r = 0; r < 8; r++) exp[r] = (r < 4) ? (16'h0400 | 16'(r)) : (16'h4400 | 16'(r));
    read_front("post_rst", exp);

    repeat (4) @(posedge clk);
    check("frame_q_empty", frame_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
